// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: length-prefixed frame -> big-endian 32-bit word writes, core held while loading.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;
  localparam state_t S_TAIL = S_CHK;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE} state_t;
  localparam state_t S_TAIL = S_DONE;
`endif

  localparam logic [31:0] LIMIT = 32'(MEM_BYTES) - BASE_ADDR;

  state_t      state, state_n;
  logic [15:0] len, len_n, word_idx, word_idx_n, words_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [23:0] shift, shift_n;
  logic [31:0] addr_n, wdata_n;
  logic        err_n, fire;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  acc, acc_n;
`endif

  assign fire = s_valid && s_ready;

  always_comb begin
    state_n    = state;
    len_n      = len;
    word_idx_n = word_idx;
    words_n    = words_loaded;
    byte_idx_n = byte_idx;
    shift_n    = shift;
    addr_n     = mem_addr;
    wdata_n    = mem_wdata;
    err_n      = err;
`ifdef LOADER_CHECKSUM_EN
    acc_n      = acc;
`endif
    case (state)
      S_IDLE: if (start) begin
        state_n    = S_LEN_HI;
        err_n      = 1'b0;
        words_n    = '0;
        word_idx_n = '0;
        byte_idx_n = '0;
`ifdef LOADER_CHECKSUM_EN
        acc_n      = '0;
`endif
      end
      S_LEN_HI: if (fire) begin
        len_n[15:8] = s_data;
        state_n     = S_LEN_LO;
      end
      S_LEN_LO: if (fire) begin
        len_n = {len[15:8], s_data};
        // 32-bit compare so 4*len cannot wrap before the bound check
        if ({14'd0, len_n, 2'b00} > LIMIT) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (len_n == 16'd0) state_n = S_TAIL;
        else                         state_n = S_DATA;
      end
      S_DATA: if (fire) begin
        shift_n    = {shift[15:0], s_data};
        byte_idx_n = byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        acc_n      = acc ^ s_data;
`endif
        if (byte_idx == 2'd3) begin
          state_n = S_WRITE;
          wdata_n = {shift, s_data};
          addr_n  = BASE_ADDR + {14'd0, word_idx, 2'b00};
        end
      end
      S_WRITE: begin
        word_idx_n = word_idx + 16'd1;
        words_n    = words_loaded + 16'd1;
        state_n    = (word_idx_n == len) ? S_TAIL : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: if (fire) begin
        if (s_data != acc) err_n = 1'b1;
        state_n = S_DONE;
      end
`endif
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len          <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      shift        <= '0;
      words_loaded <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err          <= 1'b0;
      s_ready      <= 1'b0;
      mem_write    <= 1'b0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      state        <= state_n;
      len          <= len_n;
      word_idx     <= word_idx_n;
      byte_idx     <= byte_idx_n;
      shift        <= shift_n;
      words_loaded <= words_n;
      mem_addr     <= addr_n;
      mem_wdata    <= wdata_n;
      err          <= err_n;
`ifdef LOADER_CHECKSUM_EN
      acc          <= acc_n;
      s_ready      <= (state_n == S_LEN_HI) || (state_n == S_LEN_LO) ||
                      (state_n == S_DATA) || (state_n == S_CHK);
`else
      s_ready      <= (state_n == S_LEN_HI) || (state_n == S_LEN_LO) || (state_n == S_DATA);
`endif
      mem_write    <= (state_n == S_WRITE);
      cpu_hold     <= (state_n != S_IDLE);
      busy         <= (state_n != S_IDLE);
      done         <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed + randomized bench for instr_mem_loader against a frame-level write model.
module tb_instr_mem_loader;
  localparam logic [31:0] BASE = 32'd0;
  localparam int          MEMB = 2048;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready, mem_write, cpu_hold, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_loaded;

  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic [31:0] obs_addr[$], obs_data[$];

  instr_mem_loader #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .err(err), .words_loaded(words_loaded));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: collects every strobe; a write cycle must never offer ready.
  always @(negedge clk) if (!rst) begin
    if (mem_write) begin
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
      check("ready_during_write", 32'(s_ready), 32'd0);
    end
    if (done) done_cnt++;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Present bytes in order, holding each until accepted; gap_pct = chance of an idle cycle.
  task automatic send(input logic [7:0] q[$], input int gap_pct);
    int i = 0, guard = 0;
    logic fire;
    while (i < q.size() && guard < 20000) begin
      @(negedge clk);
      s_valid = ($urandom_range(99) >= 32'(gap_pct));
      s_data  = s_valid ? q[i] : 8'($urandom);
      fire    = s_valid && s_ready;
      @(posedge clk);
      if (fire) i++;
      guard++;
    end
    #1 s_valid = 1'b0;
    check("send_complete", 32'(i), 32'(q.size()));
  endtask

  task automatic wait_done();
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 100);
    check("done_seen", 32'(done), 32'd1);
  endtask

  function automatic void build(input logic [31:0] w[$], input logic bad_chk, output logic [7:0] f[$]);
    logic [7:0] x = 8'd0;
    logic [15:0] n = 16'(w.size());
    f = {};
    f.push_back(n[15:8]);
    f.push_back(n[7:0]);
    foreach (w[i]) for (int b = 3; b >= 0; b--) begin
      f.push_back(w[i][8*b +: 8]);
      x ^= w[i][8*b +: 8];
    end
`ifdef LOADER_CHECKSUM_EN
    f.push_back(x ^ {7'd0, bad_chk});
`endif
  endfunction

  task automatic run_load(input string tag, input logic [31:0] w[$], input int gap, input logic bad_chk);
    logic [7:0] f[$];
    logic exp_err = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    exp_err = bad_chk;
`endif
    build(w, bad_chk, f);
    obs_addr = {}; obs_data = {}; done_cnt = 0;
    pulse_start();
    send(f, gap);
    wait_done();
    check({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(w.size()));
    foreach (w[i]) if (i < obs_addr.size()) begin
      check({tag, "_addr"}, obs_addr[i], BASE + 32'(4 * i));
      check({tag, "_data"}, obs_data[i], w[i]);
    end
    check({tag, "_words"}, 32'(words_loaded), 32'(w.size()));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_hold_low"}, 32'(cpu_hold), 32'd0);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    logic [31:0] basic[$], w[$];
    logic [7:0]  f[$], part[$];
    basic = {32'hE000_0000, 32'hE3A0_0014};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(s_ready), 0);  check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);     check("rst_write", 32'(mem_write), 0);
    check("rst_hold", 32'(cpu_hold), 0);  check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);      check("rst_err", 32'(err), 0);
    check("rst_words", 32'(words_loaded), 0);

    run_load("basic", basic, 0, 1'b0);
    run_load("gaps", basic, 50, 1'b0);
    for (int t = 0; t < 4; t++) begin
      w = {};
      repeat ($urandom_range(6, 1)) w.push_back($urandom);
      run_load("rand", w, 35, 1'b0);
    end
    w = {};
    repeat (512) w.push_back($urandom);
    run_load("full_mem", w, 0, 1'b0);

    // Overflow: 513 words do not fit
    obs_addr = {}; done_cnt = 0;
    pulse_start();
    f = {8'h02, 8'h01};
    send(f, 0);
    @(negedge clk);
    check("ovf_err", 32'(err), 1);
    check("ovf_busy", 32'(busy), 0);
    check("ovf_ready", 32'(s_ready), 0);
    repeat (4) @(negedge clk);
    check("ovf_nwrites", 32'(obs_addr.size()), 0);
    check("ovf_no_done", 32'(done_cnt), 0);

    // New start clears err; use that session for a zero-length frame
    pulse_start();
    check("start_clears_err", 32'(err), 0);
    check("start_busy", 32'(busy), 1);
    w = {};
    build(w, 1'b0, f);
    send(f, 0);
    @(negedge clk);
    check("zero_done_next", 32'(done), 1);
    check("zero_hold", 32'(cpu_hold), 1);
    @(negedge clk);
    check("zero_nwrites", 32'(obs_addr.size()), 0);
    check("zero_busy_low", 32'(busy), 0);
    check("zero_words", 32'(words_loaded), 0);

`ifdef LOADER_CHECKSUM_EN
    run_load("chk_bad", basic, 0, 1'b1);
    run_load("chk_good", basic, 20, 1'b0);
`endif

    // Reset in the middle of a data word
    pulse_start();
    build(basic, 1'b0, f);
    part = f[0:4];
    send(part, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_ready", 32'(s_ready), 0); check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_hold", 32'(cpu_hold), 0); check("mid_rst_write", 32'(mem_write), 0);
    check("mid_rst_words", 32'(words_loaded), 0); check("mid_rst_wdata", mem_wdata, 0);
    rst = 1'b0;
    run_load("after_rst", basic, 25, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
